// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_pick.sv
// Combinational round-robin search: first asserted req at ptr, ptr+1, ... mod 4.
module mux4_rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               found,
  output logic [1:0]         idx
);

  logic [1:0] cand;

  // Scan farthest-first so the candidate closest to ptr is the last to overwrite.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with per-owner burst limit driving a registered 4:1 data mux.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [WIDTH-1:0]    din0,
  input  logic [WIDTH-1:0]    din1,
  input  logic [WIDTH-1:0]    din2,
  input  logic [WIDTH-1:0]    din3,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [1:0]          sel,
  output logic                en,
  output logic [WIDTH-1:0]    dout,
  output logic                busy
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  arb_state_e       state;
  logic [1:0]       ptr;
  logic [3:0]       cnt;
  logic [1:0]       pick_ptr;
  logic [1:0]       pick_idx;
  logic             pick_found;
  logic             release_owner;
  logic [WIDTH-1:0] mux_p0;

  assign release_owner = !req[sel] || (cnt == BURST_MAX);

  // In GRANT the picker only matters on release, where the search starts at owner+1.
  assign pick_ptr = (state == GRANT) ? sel + 2'd1 : ptr;

  mux4_rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    case (sel)
      2'd0:    mux_p0 = din0;
      2'd1:    mux_p0 = din1;
      2'd2:    mux_p0 = din2;
      default: mux_p0 = din3;
    endcase
  end

  // Stage p0 -> registered grant/select and dout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= 2'd0;
      en    <= 1'b0;
      busy  <= 1'b0;
      ptr   <= 2'd0;
      cnt   <= 4'd0;
      dout  <= '0;
    end else begin
      dout <= en ? mux_p0 : '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state <= GRANT;
            gnt   <= idx_to_onehot(pick_idx);
            sel   <= pick_idx;
            en    <= 1'b1;
            busy  <= 1'b1;
            cnt   <= 4'd1;
          end else begin
            gnt  <= '0;
            en   <= 1'b0;
            busy <= 1'b0;
          end
        end
        GRANT: begin
          if (release_owner) begin
            ptr <= sel + 2'd1;
            if (pick_found) begin
              gnt <= idx_to_onehot(pick_idx);
              sel <= pick_idx;
              cnt <= 4'd1;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              en    <= 1'b0;
              busy  <= 1'b0;
            end
          end else if (cnt != BURST_MAX) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_mux4_rr_arbiter;

  localparam int W  = 8;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] din [4];
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         en;
  logic [W-1:0] dout;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: current owner, search start, burst length, last mux output.
  bit           m_busy;
  int           m_owner;
  int           m_ptr;
  int           m_cnt;
  bit           m_en;
  logic [W-1:0] m_dout;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .din0 (din[0]),
    .din1 (din[1]),
    .din2 (din[2]),
    .din3 (din[3]),
    .gnt  (gnt),
    .sel  (sel),
    .en   (en),
    .dout (dout),
    .busy (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_req(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_en = 0; m_dout = '0;
  endtask

  task automatic model_step();
    int w;
    m_dout = m_en ? din[m_owner] : '0;
    if (!m_busy) begin
      w = first_req(req, m_ptr);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_cnt = 1; m_en = 1;
      end else begin
        m_en = 0;
      end
    end else if (!req[m_owner] || m_cnt == MB) begin
      m_ptr = (m_owner + 1) % 4;
      w = first_req(req, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_cnt = 1;
      end else begin
        m_busy = 0; m_en = 0;
      end
    end else begin
      m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_gnt;
    exp_gnt = m_en ? (4'b0001 << m_owner) : 4'b0000;
    chk("gnt",  gnt,  exp_gnt);
    chk("sel",  sel,  m_owner);
    chk("en",   en,   m_en);
    chk("busy", busy, m_busy);
    chk("dout", dout, m_dout);
    chk("ptr",  dut.ptr, m_ptr);
    chk("inv_en_or", en, |gnt);
    chk("inv_onehot0", $onehot0(gnt), 1);
    chk("inv_sel_gnt", en ? gnt : 4'b0, en ? (4'b0001 << sel) : 4'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_gnt", gnt, 4'b0);
    chk("rst_en", en, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", sel, 0);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0;
    for (int i = 0; i < 4; i++) din[i] = W'(8'h10 * (i + 1));
    model_reset();
    #7;
    chk("por_gnt", gnt, 4'b0);
    chk("por_dout", dout, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs();

    // Single requester: burst-limit re-grant keeps gnt asserted
    din[0] = W'(1);
    req = 4'b0001;
    tick();
    chk("r031_gnt_e1", gnt, 4'b0001);
    chk("r031_sel_e1", sel, 0);
    tick();
    chk("r031_dout_e2", dout, 1);
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("r031_gnt_hold", gnt, 4'b0001);
    end

    // All requesting from reset: 0,1,2,3,0 with 4 cycles each
    pulse_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("r032_sel", sel, (c / 4) % 4);
      chk("r032_gnt", gnt, 4'b0001 << ((c / 4) % 4));
    end

    // Owner drops request: immediate hand-off, pointer moves past old owner
    pulse_reset();
    req = 4'b0100;
    tick();
    chk("r033_gnt2", gnt, 4'b0100);
    tick();
    req = 4'b0001;
    tick();
    chk("r033_gnt0", gnt, 4'b0001);
    chk("r033_ptr", dut.ptr, 3);

    // Wrap-around from ptr = 3
    pulse_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    chk("r034_idle", gnt, 4'b0000);
    chk("r034_ptr", dut.ptr, 3);
    req = 4'b1001;
    tick();
    chk("r034_first", gnt, 4'b1000);
    for (int c = 0; c < 3; c++) tick();
    tick();
    chk("r034_second", gnt, 4'b0001);

    // Reset mid-grant aborts everything; restart from requester 0
    pulse_reset();
    req = 4'b0010;
    tick();
    chk("r035_gnt1", gnt, 4'b0010);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("r035_gnt_rst", gnt, 4'b0);
    chk("r035_en_rst", en, 0);
    chk("r035_dout_rst", dout, 0);
    req = 4'b1111;
    #3;
    rst_n = 1'b1;
    tick();
    chk("r035_first", gnt, 4'b0001);

    // Randomized traffic with held request patterns and fresh data
    for (int blk = 0; blk < 120; blk++) begin
      int hold;
      req  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) req = 4'b0;
      hold = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) begin
        for (int i = 0; i < 4; i++) din[i] = W'($urandom);
        tick();
      end
      if (blk == 60) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
